instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  begin execution from current pc; sampled only in IDLE.
REQ-005 halt_req  input  1  stop at next instruction boundary.
REQ-006 instr  input  60  instruction word from instruction memory; opcode = instr[59:56], target/offset = instr[15:0].
REQ-007 imem_ready  input  1  instruction memory data valid this cycle.
REQ-008 branch_cond  input  1  ALU compare result; valid during EXEC.
REQ-009 pc  output  16  program counter / instruction address.
REQ-010 imem_req  output  1  fetch request; held until imem_ready.
REQ-011 ir  output  60  latched instruction register.
REQ-012 alu_go  output  1  one-cycle ALU execute strobe.
REQ-013 imm_sel  output  1  ALU source = immediate.
REQ-014 reg_we  output  1  register-file write strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 retired  output  16  count of completed instructions.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB; it SHALL be a Moore machine with imem_req, alu_go, reg_we and busy decoded from the current state only.
REQ-018 IDLE: start=1 -> FETCH; otherwise remain; pc, ir and retired are held.
REQ-019 FETCH: imem_req=1; imem_ready=0 -> remain, with no cycle limit; imem_ready=1 -> ir<=instr, next state DECODE.
REQ-020 DECODE: one cycle; imm_sel<=1 for opcodes 9-11 and 0 for all others; next state EXEC.
REQ-021 EXEC: alu_go=1 for exactly this one cycle; the next-state and pc action SHALL depend on ir[59:56] as follows:
  - opcodes 0-4, 6-8 (R-type) and 9-11 (I-type): go to WB.
  - opcode 5 (jump): pc<=ir[15:0]; this ends the instruction.
  - opcodes 12-15 (branch): branch_cond=1 -> pc<=pc+1+sign_extend(ir[15:0]); branch_cond=0 -> pc<=pc+1; this ends the instruction.
REQ-022 WB: reg_we=1 for exactly this one cycle; pc<=pc+1; this ends the instruction.
REQ-023 Instruction end: retired<=retired+1; next state is IDLE if halt_req=1 in that cycle, else FETCH.
REQ-024 halt_req SHALL be ignored in IDLE, FETCH and DECODE; it takes effect only at instruction end.
REQ-025 All pc arithmetic SHALL be modulo 2^16, so 0xFFFF+1 = 0x0000 and a negative offset may wrap below 0.
REQ-026 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-027 Latency with imem_ready=1 on the first FETCH cycle:
  - R-type and I-type: 4 cycles.
  - jump and branch: 3 cycles.
  - each cycle of imem_ready=0 adds 1 cycle.
REQ-028 imm_sel SHALL hold its DECODE value until the next DECODE.
REQ-029 ir SHALL change only on FETCH with imem_ready=1.

Reset
REQ-030 While rst=1, regardless of clk, the block SHALL force state=IDLE, pc=0, ir=0, retired=0, imm_sel=0, imem_req=0, alu_go=0, reg_we=0, busy=0.
REQ-031 Reset asserted mid-instruction SHALL abort that instruction: no reg_we pulse, no retired increment, no pc update.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-033 Straight-line R-type: after reset, start=1; instr opcode 2; imem_ready always 1 -> reg_we pulses on cycle 4; pc=1; retired=1; imm_sel=0.
REQ-034 I-type with fetch stall: opcode 10; imem_ready low for 3 FETCH cycles -> imem_req high for 4 cycles; imm_sel=1; reg_we 7 cycles after start; ir stable until ready.
REQ-035 Jump and branches:
  - opcode 5, instr[15:0]=0x1234 -> pc=0x1234 after 3 cycles, no reg_we.
  - opcode 13, pc=0x0010, offset=0xFFF0, branch_cond=1 -> pc=0x0001.
  - same with branch_cond=0 -> pc=0x0011.
REQ-036 Wrap: pc=0xFFFF, R-type -> pc=0x0000. retired=0xFFFF plus one completion -> retired=0x0000.
REQ-037 Halt: halt_req=1 raised during FETCH of an R-type -> instruction completes (reg_we pulses, retired+1), then IDLE with busy=0. A new start resumes at pc.
REQ-038 Reset mid-EXEC: rst pulsed asynchronously between edges -> all outputs zero immediately, no reg_we, state IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_sequencer : IDLE/FETCH/DECODE/EXEC/WB instruction control sequencer
// rev 1.0
// ----------------------------------------------------------------------------
module instr_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic [59:0] instr,
  input  logic        imem_ready,
  input  logic        branch_cond,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic [59:0] ir,
  output logic        alu_go,
  output logic        imm_sel,
  output logic        reg_we,
  output logic        busy,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_JUMP = 4'd5;

  state_t      state;
  state_t      nxt;
  state_t      end_state;
  logic [3:0]  opcode;
  logic [15:0] offset;
  logic [15:0] pc_inc;
  logic        is_jump;
  logic        is_branch;

  assign opcode    = ir[59:56];
  assign offset    = ir[15:0];
  assign pc_inc    = pc + 16'd1;
  assign is_jump   = (opcode == OP_JUMP);
  assign is_branch = (opcode[3:2] == 2'b11);
  // halt is only honoured at the boundary where an instruction retires
  assign end_state = halt_req ? IDLE : FETCH;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   if (imem_ready) nxt = DECODE;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = (is_jump || is_branch) ? end_state : WB;
      WB:      nxt = end_state;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= 16'd0;
      ir       <= 60'd0;
      retired  <= 16'd0;
      imm_sel  <= 1'b0;
      imem_req <= 1'b0;
      alu_go   <= 1'b0;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ready) ir <= instr;
        DECODE: imm_sel <= (opcode >= 4'd9) && (opcode <= 4'd11);
        EXEC: begin
          if (is_jump) begin
            pc      <= offset;
            retired <= retired + 16'd1;
          end else if (is_branch) begin
            // a 16-bit offset added modulo 2^16 is already its own sign extension
            pc      <= branch_cond ? (pc_inc + offset) : pc_inc;
            retired <= retired + 16'd1;
          end
        end
        WB: begin
          pc      <= pc_inc;
          retired <= retired + 16'd1;
        end
        default: ;
      endcase
      state    <= nxt;
      imem_req <= (nxt == FETCH);
      alu_go   <= (nxt == EXEC);
      reg_we   <= (nxt == WB);
      busy     <= (nxt != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_sequencer : randomized scoreboard bench for instr_sequencer
// rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [59:0] instr;
  logic        imem_ready;
  logic        branch_cond;
  logic [15:0] pc;
  logic        imem_req;
  logic [59:0] ir;
  logic        alu_go;
  logic        imm_sel;
  logic        reg_we;
  logic        busy;
  logic [15:0] retired;

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .instr      (instr),
    .imem_ready (imem_ready),
    .branch_cond(branch_cond),
    .pc         (pc),
    .imem_req   (imem_req),
    .ir         (ir),
    .alu_go     (alu_go),
    .imm_sel    (imm_sel),
    .reg_we     (reg_we),
    .busy       (busy),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ret;
    logic [59:0] ir;
    logic        imm;
    int          we;
    int          req;
    int          lat;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ret;
  bit          in_idle;
  bit          abort_flag = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc"},       pc,       64'd0);
    chk({tag, "_ir"},       ir,       64'd0);
    chk({tag, "_retired"},  retired,  64'd0);
    chk({tag, "_imm_sel"},  imm_sel,  64'd0);
    chk({tag, "_imem_req"}, imem_req, 64'd0);
    chk({tag, "_alu_go"},   alu_go,   64'd0);
    chk({tag, "_reg_we"},   reg_we,   64'd0);
    chk({tag, "_busy"},     busy,     64'd0);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   fetch_cyc = 0;
  int   cnt_we = 0, cnt_alu = 0, cnt_req = 0;
  logic prev_req = 1'b0;
  logic [15:0] prev_ret = 16'd0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (rst || abort_flag) begin
      cnt_we = 0; cnt_alu = 0; cnt_req = 0;
      prev_ret   = retired;
      prev_req   = imem_req;
      abort_flag = 1'b0;
    end else begin
      if (retired != prev_ret) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", retired, prev_ret);
        end else begin
          me = sb.pop_front();
          chk("pc",              pc,              me.pc);
          chk("retired",         retired,         me.ret);
          chk("ir",              ir,              me.ir);
          chk("imm_sel",         imm_sel,         me.imm);
          chk("reg_we_pulses",   cnt_we,          me.we);
          chk("alu_go_pulses",   cnt_alu,         64'd1);
          chk("imem_req_cycles", cnt_req,         me.req);
          chk("latency",         cyc - fetch_cyc, me.lat);
          chk("busy_after",      busy,            !me.halt);
        end
        cnt_we = 0; cnt_alu = 0; cnt_req = 0;
        prev_ret = retired;
      end
      if (imem_req && !prev_req) fetch_cyc = cyc;
      prev_req = imem_req;
      cnt_req += int'(imem_req);
      cnt_alu += int'(alu_go);
      cnt_we  += int'(reg_we);
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic run_instr(input logic [3:0] op, input logic [15:0] off, input int stalls,
                           input logic cond, input logic hlt);
    exp_t        e;
    logic [59:0] word;
    bit          ri;
    int          g;
    word = {op, 24'($urandom), 16'($urandom), off};
    ri   = !(op == 4'd5 || op >= 4'd12);
    if (op == 4'd5)       m_pc = off;
    else if (op >= 4'd12) m_pc = m_pc + 16'd1 + (cond ? off : 16'd0);
    else                  m_pc = m_pc + 16'd1;
    m_ret  = m_ret + 16'd1;
    e.pc   = m_pc;
    e.ret  = m_ret;
    e.ir   = word;
    e.imm  = (op >= 4'd9 && op <= 4'd11);
    e.we   = ri ? 1 : 0;
    e.req  = stalls + 1;
    e.lat  = stalls + (ri ? 4 : 3);
    e.halt = hlt;
    sb.push_back(e);

    if (in_idle) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    g = 0;
    while (!imem_req && g < 20) begin @(negedge clk); g++; end
    if (!imem_req) chk("fetch_timeout", imem_req, 64'd1);

    branch_cond = cond;
    halt_req    = hlt;
    for (int i = 0; i < stalls; i++) begin
      imem_ready = 1'b0;
      instr      = 60'({$urandom, $urandom});
      @(negedge clk);
    end
    imem_ready = 1'b1;
    instr      = word;
    @(negedge clk);
    imem_ready = 1'b0;
    instr      = 60'({$urandom, $urandom});
    g = 0;
    while (busy && !imem_req && g < 20) begin @(negedge clk); g++; end
    if (busy && !imem_req) chk("end_timeout", busy, 64'd0);
    in_idle = !busy;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; instr = '0;
    imem_ready = 1'b0; branch_cond = 1'b0;
    m_pc = 16'd0; m_ret = 16'd0; in_idle = 1'b1;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_wait_busy", busy, 64'd0);

    // abort an instruction with an asynchronous reset pulse during EXEC
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    imem_ready = 1'b1;
    instr      = {4'd2, 56'hABCDEF_0123_4567};
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("exec_alu_go", alu_go, 64'd1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #1 rst = 1'b0;
    abort_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_reg_we", reg_we, 64'd0);
    end
    chk("abort_busy", busy, 64'd0);
    chk("abort_pc", pc, 64'd0);
    chk("abort_retired", retired, 64'd0);
    in_idle = 1'b1;

    // directed cases
    run_instr(4'd2,  16'($urandom), 0, 1'b0, 1'b0);
    run_instr(4'd10, 16'($urandom), 3, 1'b0, 1'b0);
    run_instr(4'd5,  16'h1234,      0, 1'b0, 1'b0);
    run_instr(4'd5,  16'h0010,      0, 1'b0, 1'b0);
    run_instr(4'd13, 16'hFFF0,      0, 1'b1, 1'b0);
    run_instr(4'd5,  16'h0010,      0, 1'b0, 1'b0);
    run_instr(4'd13, 16'hFFF0,      0, 1'b0, 1'b0);
    run_instr(4'd5,  16'hFFFF,      0, 1'b0, 1'b0);
    run_instr(4'd2,  16'($urandom), 0, 1'b0, 1'b0);
    run_instr(4'd3,  16'($urandom), 1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("halt_idle_busy", busy, 64'd0);
    chk("halt_idle_pc", pc, m_pc);
    run_instr(4'd7,  16'($urandom), 0, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      run_instr(4'($urandom_range(0, 15)), 16'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                1'($urandom), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
